match_controller: RTL and testbench

Sequences a Ryu-vs-Akuma bout for the display datapath. Owns both fighters' health registers, accepts and rate-limits hit requests from the combat/collision logic, detects KO, and drives the `death` flag consumed by the color mapper for the KO overlay. It also produces `freeze`, which tells the movement and sprite-index logic to hold. It runs on the system clock and advances its frame-based timers on a one-cycle per-frame tick.

---
 rtl/match_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_match_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// match_controller: sequences a Ryu-vs-Akuma bout.
// It owns both health registers and rate-limits hit requests with per-attacker
// cooldowns. It detects KO and drives the death/freeze/winner outputs.
// Optional feature macro: MATCH_ROUND_TIMER_EN. When defined, a 99-second round
// timer runs during FIGHT, and the round ends in KO when the timer expires.
// All timers advance on the one-cycle frame_tick pulse.
module match_controller #(
  parameter logic [7:0] MAX_HEALTH   = 8'd160,
  parameter logic [7:0] HIT_COOLDOWN = 8'd30,
  parameter logic [7:0] KO_FRAMES    = 8'd180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       ryu_hit_req,
  input  logic [7:0] ryu_dmg,
  input  logic       akuma_hit_req,
  input  logic [7:0] akuma_dmg,
  output logic [7:0] RyuHealth,
  output logic [7:0] AkumaHealth,
  output logic       death,
  output logic       freeze,
  output logic [1:0] winner,
  output logic       ryu_hit_ack,
  output logic       akuma_hit_ack,
  output logic [6:0] round_time,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FIGHT = 2'b01,
    ST_KO    = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Health subtraction that clamps at zero instead of wrapping.
  function automatic logic [7:0] sat_sub(input logic [7:0] minuend,
                                         input logic [7:0] amount);
    logic [7:0] result;
    if (amount >= minuend) begin
      result = 8'd0;
    end else begin
      result = minuend - amount;
    end
    return result;
  endfunction

  // The fighter with more health wins, and equal health is a draw.
  // This also covers a health KO: the fighter who is still alive has more
  // health, and a double KO means both are at zero, which is equal.
  function automatic logic [1:0] pick_winner(input logic [7:0] ryu_h,
                                             input logic [7:0] akuma_h);
    logic [1:0] result;
    if (ryu_h == akuma_h) begin
      result = 2'b11;
    end else if (ryu_h > akuma_h) begin
      result = 2'b01;
    end else begin
      result = 2'b10;
    end
    return result;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] ryu_health_q, ryu_health_d;
  logic [7:0] akuma_health_q, akuma_health_d;
  logic [7:0] ryu_cd_q, ryu_cd_d;       // Ryu's lockout as an attacker
  logic [7:0] akuma_cd_q, akuma_cd_d;   // Akuma's lockout as an attacker
  logic [7:0] ko_cnt_q, ko_cnt_d;
  logic [1:0] winner_q, winner_d;
  logic       ryu_ack_q, ryu_ack_d;
  logic       akuma_ack_q, akuma_ack_d;
  logic       death_q, death_d;
  logic       freeze_q, freeze_d;
  logic       time_up_s;

`ifdef MATCH_ROUND_TIMER_EN
  logic [6:0] round_time_q, round_time_d;
  logic [5:0] frame_div_q, frame_div_d;   // counts 60 frames per second

  assign time_up_s  = (round_time_q == 7'd0);
  assign round_time = round_time_q;
`else
  assign time_up_s  = 1'b0;
  assign round_time = 7'd0;
`endif

  // Next-state logic for the bout FSM, health, cooldowns and KO counter.
  always_comb begin
    state_d        = state_q;
    ryu_health_d   = ryu_health_q;
    akuma_health_d = akuma_health_q;
    ryu_cd_d       = ryu_cd_q;
    akuma_cd_d     = akuma_cd_q;
    ko_cnt_d       = ko_cnt_q;
    winner_d       = winner_q;
    ryu_ack_d      = 1'b0;
    akuma_ack_d    = 1'b0;
`ifdef MATCH_ROUND_TIMER_EN
    round_time_d   = round_time_q;
    frame_div_d    = frame_div_q;
`endif

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d        = ST_FIGHT;
          ryu_health_d   = MAX_HEALTH;
          akuma_health_d = MAX_HEALTH;
          ryu_cd_d       = 8'd0;
          akuma_cd_d     = 8'd0;
          ko_cnt_d       = 8'd0;
          winner_d       = 2'b00;
`ifdef MATCH_ROUND_TIMER_EN
          round_time_d   = 7'd99;
          frame_div_d    = 6'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end

      ST_FIGHT: begin
        // A KO takes priority over any hit arriving in the same cycle, so a
        // finished fighter cannot turn a clean win into a draw.
        if ((ryu_health_q == 8'd0) || (akuma_health_q == 8'd0) || time_up_s) begin
          state_d  = ST_KO;
          winner_d = pick_winner(ryu_health_q, akuma_health_q);
          ko_cnt_d = KO_FRAMES;
        end else begin
          // Ryu attacking Akuma. The cooldown is judged on its current value,
          // so the tick that takes the cooldown to zero still rejects a hit.
          if (ryu_hit_req && (ryu_cd_q == 8'd0)) begin
            akuma_health_d = sat_sub(akuma_health_q, ryu_dmg);
            ryu_cd_d       = HIT_COOLDOWN;
            ryu_ack_d      = 1'b1;
          end else if (frame_tick && (ryu_cd_q != 8'd0)) begin
            ryu_cd_d = ryu_cd_q - 8'd1;
          end else begin
            ryu_cd_d = ryu_cd_q;
          end

          // Akuma attacking Ryu; evaluated independently of Ryu's hit.
          if (akuma_hit_req && (akuma_cd_q == 8'd0)) begin
            ryu_health_d = sat_sub(ryu_health_q, akuma_dmg);
            akuma_cd_d   = HIT_COOLDOWN;
            akuma_ack_d  = 1'b1;
          end else if (frame_tick && (akuma_cd_q != 8'd0)) begin
            akuma_cd_d = akuma_cd_q - 8'd1;
          end else begin
            akuma_cd_d = akuma_cd_q;
          end

`ifdef MATCH_ROUND_TIMER_EN
          // The round clock only runs here, while time remains.
          if (frame_tick) begin
            if (frame_div_q == 6'd59) begin
              frame_div_d  = 6'd0;
              round_time_d = round_time_q - 7'd1;
            end else begin
              frame_div_d  = frame_div_q + 6'd1;
            end
          end else begin
            frame_div_d = frame_div_q;
          end
`endif
        end
      end

      ST_KO: begin
        // The overlay lasts exactly KO_FRAMES ticks. The move to OVER happens
        // on the tick that would take the counter to zero.
        if (frame_tick) begin
          if (ko_cnt_q <= 8'd1) begin
            ko_cnt_d = 8'd0;
            state_d  = ST_OVER;
          end else begin
            ko_cnt_d = ko_cnt_q - 8'd1;
          end
        end else begin
          ko_cnt_d = ko_cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    death_d  = (state_d == ST_KO) || (state_d == ST_OVER);
    freeze_d = (state_d != ST_FIGHT);
  end

  // State and datapath registers; a synchronous Reset overrides every update.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      ryu_health_q   <= MAX_HEALTH;
      akuma_health_q <= MAX_HEALTH;
      ryu_cd_q       <= 8'd0;
      akuma_cd_q     <= 8'd0;
      ko_cnt_q       <= 8'd0;
      winner_q       <= 2'b00;
      ryu_ack_q      <= 1'b0;
      akuma_ack_q    <= 1'b0;
      death_q        <= 1'b0;
      freeze_q       <= 1'b1;
    end else begin
      state_q        <= state_d;
      ryu_health_q   <= ryu_health_d;
      akuma_health_q <= akuma_health_d;
      ryu_cd_q       <= ryu_cd_d;
      akuma_cd_q     <= akuma_cd_d;
      ko_cnt_q       <= ko_cnt_d;
      winner_q       <= winner_d;
      ryu_ack_q      <= ryu_ack_d;
      akuma_ack_q    <= akuma_ack_d;
      death_q        <= death_d;
      freeze_q       <= freeze_d;
    end
  end

`ifdef MATCH_ROUND_TIMER_EN
  // Round clock registers; the timer reads a full 99 s out of reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      round_time_q <= 7'd99;
      frame_div_q  <= 6'd0;
    end else begin
      round_time_q <= round_time_d;
      frame_div_q  <= frame_div_d;
    end
  end
`endif

  assign state         = state_q;
  assign RyuHealth     = ryu_health_q;
  assign AkumaHealth   = akuma_health_q;
  assign winner        = winner_q;
  assign ryu_hit_ack   = ryu_ack_q;
  assign akuma_hit_ack = akuma_ack_q;
  assign death         = death_q;
  assign freeze        = freeze_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller, using a scoreboard of expected
// {RyuHealth, AkumaHealth, ryu_ack, akuma_ack, state} per driven cycle.
module tb_match_controller;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, start, ryu_hit_req, akuma_hit_req;
  logic [7:0] ryu_dmg, akuma_dmg;
  logic [7:0] RyuHealth, AkumaHealth;
  logic       death, freeze, ryu_hit_ack, akuma_hit_ack;
  logic [1:0] winner, state;
  logic [6:0] round_time;

  typedef struct packed {
    logic [7:0] rh;
    logic [7:0] ah;
    logic       ra;
    logic       aa;
    logic [1:0] st;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  exp_t obs;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef MATCH_ROUND_TIMER_EN
  localparam logic [6:0] RT_RESET = 7'd99;
`else
  localparam logic [6:0] RT_RESET = 7'd0;
`endif

  always #5 Clk = ~Clk;

  match_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .ryu_hit_req(ryu_hit_req), .ryu_dmg(ryu_dmg),
    .akuma_hit_req(akuma_hit_req), .akuma_dmg(akuma_dmg),
    .RyuHealth(RyuHealth), .AkumaHealth(AkumaHealth), .death(death),
    .freeze(freeze), .winner(winner), .ryu_hit_ack(ryu_hit_ack),
    .akuma_hit_ack(akuma_hit_ack), .round_time(round_time), .state(state)
  );

  // Drive one cycle of inputs, step past the edge, then return inputs to idle.
  task automatic cyc(input logic rq, input logic [7:0] rd, input logic aq,
                     input logic [7:0] ad, input logic tk, input logic st);
    ryu_hit_req = rq; ryu_dmg = rd; akuma_hit_req = aq; akuma_dmg = ad;
    frame_tick = tk; start = st;
    @(posedge Clk); #1;
    ryu_hit_req = 1'b0; ryu_dmg = 8'd0; akuma_hit_req = 1'b0; akuma_dmg = 8'd0;
    frame_tick = 1'b0; start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'd9, 1'b1, 8'd9, 1'b1, 1'b0);
    Reset = 1'b0;
    n_vec++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state got %b want 00", state); end
    n_vec++; if (RyuHealth !== 8'd160 || AkumaHealth !== 8'd160) begin n_err++; $display("FAIL reset_health got %0d/%0d want 160/160", RyuHealth, AkumaHealth); end
    n_vec++; if ({death, freeze, winner, ryu_hit_ack, akuma_hit_ack} !== 6'b010000) begin n_err++; $display("FAIL reset_flags got %b want 010000", {death, freeze, winner, ryu_hit_ack, akuma_hit_ack}); end
    n_vec++; if (round_time !== RT_RESET) begin n_err++; $display("FAIL reset_round_time got %0d want %0d", round_time, RT_RESET); end
  endtask

  task automatic test_start;
    sb_q.push_back('{8'd160, 8'd160, 1'b0, 1'b0, 2'b01});
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL start got %h want %h", obs, e); end
    n_vec++; if ({freeze, death, winner} !== 4'b0000) begin n_err++; $display("FAIL start_flags got %b want 0000", {freeze, death, winner}); end
  endtask

  task automatic test_cooldown;
    // Accepted hit, then one-pulse ack, then rejects while locked out.
    sb_q.push_back('{8'd160, 8'd135, 1'b1, 1'b0, 2'b01});
    cyc(1'b1, 8'd25, 1'b0, 8'd0, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL hit_accept got %h want %h", obs, e); end
    sb_q.push_back('{8'd160, 8'd135, 1'b0, 1'b0, 2'b01});
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL ack_single_pulse got %h want %h", obs, e); end
    ticks(10);
    sb_q.push_back('{8'd160, 8'd135, 1'b0, 1'b0, 2'b01});
    cyc(1'b1, 8'd25, 1'b0, 8'd0, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL hit_reject_cooldown got %h want %h", obs, e); end
    ticks(19);
    // This request shares the cycle with the tick that clears the cooldown.
    sb_q.push_back('{8'd160, 8'd135, 1'b0, 1'b0, 2'b01});
    cyc(1'b1, 8'd25, 1'b0, 8'd0, 1'b1, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL hit_reject_on_zero_tick got %h want %h", obs, e); end
    sb_q.push_back('{8'd160, 8'd110, 1'b1, 1'b0, 2'b01});
    cyc(1'b1, 8'd25, 1'b0, 8'd0, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL hit_after_cooldown got %h want %h", obs, e); end
  endtask

  task automatic test_ko;
    ticks(30);
    sb_q.push_back('{8'd160, 8'd10, 1'b1, 1'b0, 2'b01});
    cyc(1'b1, 8'd100, 1'b0, 8'd0, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL health_to_10 got %h want %h", obs, e); end
    ticks(30);
    sb_q.push_back('{8'd160, 8'd0, 1'b1, 1'b0, 2'b01});
    cyc(1'b1, 8'd40, 1'b0, 8'd0, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL saturate_zero got %h want %h", obs, e); end
    sb_q.push_back('{8'd160, 8'd0, 1'b0, 1'b0, 2'b10});
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL ko_entry got %h want %h", obs, e); end
    n_vec++; if ({death, freeze, winner} !== 4'b1101) begin n_err++; $display("FAIL ko_flags got %b want 1101", {death, freeze, winner}); end
    // Hits and start are ignored during KO.
    sb_q.push_back('{8'd160, 8'd0, 1'b0, 1'b0, 2'b10});
    cyc(1'b0, 8'd0, 1'b1, 8'd50, 1'b0, 1'b1);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL ko_ignores_inputs got %h want %h", obs, e); end
    ticks(179);
    n_vec++; if (state !== 2'b10) begin n_err++; $display("FAIL ko_179_ticks got %b want 10", state); end
    ticks(1);
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_vec++; if ({state, death, winner} !== 5'b11101) begin n_err++; $display("FAIL over_after_180 got %b want 11101", {state, death, winner}); end
    sb_q.push_back('{8'd160, 8'd160, 1'b0, 1'b0, 2'b01});
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL restart_from_over got %h want %h", obs, e); end
    n_vec++; if ({winner, death} !== 3'b000) begin n_err++; $display("FAIL restart_flags got %b want 000", {winner, death}); end
  endtask

  task automatic test_back_to_back;
    // Simultaneous hits are applied independently, down to a double KO.
    sb_q.push_back('{8'd5, 8'd5, 1'b1, 1'b1, 2'b01});
    cyc(1'b1, 8'd155, 1'b1, 8'd155, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL simul_hits got %h want %h", obs, e); end
    ticks(30);
    sb_q.push_back('{8'd0, 8'd0, 1'b1, 1'b1, 2'b01});
    cyc(1'b1, 8'd5, 1'b1, 8'd5, 1'b0, 1'b0);
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL double_zero got %h want %h", obs, e); end
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_vec++; if ({state, winner, death} !== 5'b10111) begin n_err++; $display("FAIL draw_ko got %b want 10111", {state, winner, death}); end
  endtask

  task automatic test_reset_mid_ko;
    ticks(20);
    Reset = 1'b1;
    sb_q.push_back('{8'd160, 8'd160, 1'b0, 1'b0, 2'b00});
    cyc(1'b1, 8'd10, 1'b1, 8'd10, 1'b1, 1'b1);
    Reset = 1'b0;
    e = sb_q.pop_front(); obs = {RyuHealth, AkumaHealth, ryu_hit_ack, akuma_hit_ack, state};
    n_vec++; if (obs !== e) begin n_err++; $display("FAIL reset_mid_ko got %h want %h", obs, e); end
    n_vec++; if ({death, freeze, winner} !== 4'b0100) begin n_err++; $display("FAIL reset_mid_ko_flags got %b want 0100", {death, freeze, winner}); end
  endtask

  task automatic test_round_timer;
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
`ifdef MATCH_ROUND_TIMER_EN
    ticks(59);
    n_vec++; if (round_time !== 7'd99) begin n_err++; $display("FAIL rt_59 got %0d want 99", round_time); end
    ticks(1);
    n_vec++; if (round_time !== 7'd98) begin n_err++; $display("FAIL rt_60 got %0d want 98", round_time); end
    ticks(5880);
    n_vec++; if ({round_time, state} !== 9'b000000001) begin n_err++; $display("FAIL rt_zero got %0d/%b want 0/01", round_time, state); end
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_vec++; if ({state, winner} !== 4'b1011) begin n_err++; $display("FAIL rt_draw got %b want 1011", {state, winner}); end
    Reset = 1'b1; cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0); Reset = 1'b0;
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b1, 8'd60, 1'b0, 8'd0, 1'b0, 1'b0);
    ticks(5940);
    cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_vec++; if ({state, winner, AkumaHealth} !== {2'b10, 2'b01, 8'd100}) begin n_err++; $display("FAIL rt_ryu_wins got %b/%b/%0d want 10/01/100", state, winner, AkumaHealth); end
`else
    ticks(200);
    n_vec++; if ({round_time, state} !== 9'b000000001) begin n_err++; $display("FAIL no_timer got %0d/%b want 0/01", round_time, state); end
`endif
  endtask

  initial begin
    Reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
    ryu_hit_req = 1'b0; ryu_dmg = 8'd0; akuma_hit_req = 1'b0; akuma_dmg = 8'd0;
    #1;
    test_reset();
    test_start();
    test_cooldown();
    test_ko();
    test_back_to_back();
    test_reset_mid_ko();
    test_round_timer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d vectors", n_vec);
    $fatal(1, "timeout");
  end

endmodule
